// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Sits directly after the 4x4 array multiplier. Takes a stream of unsigned
//   8-bit products over a valid/ready handshake, adds each group of N_TERMS
//   products together and presents the group total on a valid/ready result
//   port. Typical use: small dot products and FIR taps.
//
// Parameters
//   N_TERMS  products per result (2..256)
//   ACC_W    accumulator / result width (9..32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort: drops the partial sum and any pending result
//   in_valid   in_prod is valid this cycle
//   in_ready   block accepts in_prod this cycle (high while accumulating)
//   in_prod    unsigned product from the multiplier
//   out_valid  out_sum / out_ovf hold a result
//   out_ready  downstream takes the result (ignored while accumulating)
//   out_sum    group total modulo 2^ACC_W
//   out_ovf    a carry out of ACC_W occurred somewhere in the group
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned     CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_ovf_q, sum_ovf_d;

  // One extra bit on the adder captures the carry out of the accumulator.
  logic [ACC_W:0]   add_w;

  always_comb begin
    add_w = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, in_prod};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_HOLD);

    if (clear) begin
      // in_ready keeps its state value: the presented input is simply dropped.
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              sum_d     = add_w[ACC_W-1:0];
              sum_ovf_d = ovf_q | add_w[ACC_W];
              acc_d     = '0;
              cnt_d     = '0;
              ovf_d     = 1'b0;
              state_d   = ST_HOLD;
            end else begin
              acc_d = add_w[ACC_W-1:0];
              ovf_d = ovf_q | add_w[ACC_W];
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  assign out_sum = sum_q;
  assign out_ovf = sum_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//   Drives two accumulators (ACC_W=16 and ACC_W=9, both N_TERMS=4) from the
//   same stimulus. A negedge monitor keeps a group-level reference model
//   (running integer total, term count, queue of finished totals) and checks
//   both DUTs every cycle; directed tests add explicit constant checks.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_sum9;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_results = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N_TERMS(N), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  product_accumulator #(.N_TERMS(N), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod),
    .out_valid(out_valid9), .out_ready(out_ready),
    .out_sum(out_sum9), .out_ovf(out_ovf9)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_part = 0;
  int unsigned m_cnt  = 0;
  int unsigned m_pend[$];

  always @(negedge clk) begin
    bit m_hold;
    bit m_accept;
    if (!rst_n) begin
      m_part = 0;
      m_cnt  = 0;
      m_pend.delete();
    end else begin
      m_hold = (m_pend.size() != 0);
      check_eq("out_valid", out_valid, m_hold);
      check_eq("in_ready", in_ready, !m_hold);
      check_eq("out_valid9", out_valid9, m_hold);
      check_eq("in_ready9", in_ready9, !m_hold);
      if (m_hold) begin
        check_eq("sum16", out_sum, m_pend[0] % 65536);
        check_eq("ovf16", out_ovf, m_pend[0] >= 65536);
        check_eq("sum9", out_sum9, m_pend[0] % 512);
        check_eq("ovf9", out_ovf9, m_pend[0] >= 512);
      end
      if (clear) begin
        m_part = 0;
        m_cnt  = 0;
        m_pend.delete();
      end else begin
        m_accept = in_valid && !m_hold;
        if (m_hold && out_ready) begin
          void'(m_pend.pop_front());
          n_results++;
        end
        if (m_accept) begin
          m_part += in_prod;
          m_cnt++;
          if (m_cnt == N) begin
            m_pend.push_back(m_part);
            m_part = 0;
            m_cnt  = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pop_valid_drop", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    #3;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Test 1 / 3: four 225s back to back
    send(8'd225); send(8'd225); send(8'd225);
    check_eq("t1_not_yet_valid", out_valid, 0);
    send(8'd225);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_sum", out_sum, 900);
    check_eq("t1_ovf", out_ovf, 0);
    check_eq("t1_in_ready", in_ready, 0);
    check_eq("t3_sum9", out_sum9, 388);
    check_eq("t3_ovf9", out_ovf9, 1);
    pop();
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    check_eq("t3b_sum9", out_sum9, 4);
    check_eq("t3b_ovf9", out_ovf9, 0);
    pop();

    // Test 2: gaps on input, held result with a stalled downstream
    send(8'd1); tick(); tick();
    send(8'd2); tick();
    send(8'd3);
    send(8'd4);
    in_valid = 1'b1;
    in_prod  = 8'd99;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_valid", out_valid, 1);
      check_eq("t2_sum", out_sum, 10);
      check_eq("t2_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    pop();

    // Test 4: clear with an input presented
    send(8'd7); send(8'd8);
    in_valid = 1'b1; in_prod = 8'd50; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_eq("t4_after_clear_valid", out_valid, 0);
    send(8'd5); send(8'd5); send(8'd5); send(8'd5);
    check_eq("t4_sum", out_sum, 20);
    pop();

    // Test 5: asynchronous reset in the middle of HOLD
    send(8'd10); send(8'd10); send(8'd10); send(8'd10);
    check_eq("t5_hold_sum", out_sum, 40);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_sum", out_sum, 0);
    check_eq("t5_rst_ovf", out_ovf, 0);
    check_eq("t5_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Test 6: random stream, random backpressure, rare clears
    n_results = 0;
    for (int cyc = 0; cyc < 30000 && n_results < 1000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 8'($urandom);
      out_ready = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    check_eq("t6_groups_done", n_results >= 1000, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
